// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle datapath control FSM (optional jump decode via CTRL_JUMP_EN)
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_IEXEC   = 4'd8,
    S_IWB     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state_q, state_d;

  // Instruction classes, decoded straight from the (stable) instruction register fields
  logic op_lw, op_sw, op_ori, op_beq, op_j, rtype_ok, funct_subu, decode_legal;

  assign op_lw      = (Op == 6'b100011);
  assign op_sw      = (Op == 6'b101011);
  assign op_ori     = (Op == 6'b001101);
  assign op_beq     = (Op == 6'b000100);
  assign funct_subu = (Funct == 6'b100011);
  assign rtype_ok   = (Op == 6'b000000) && ((Funct == 6'b100001) || funct_subu);
`ifdef CTRL_JUMP_EN
  assign op_j       = (Op == 6'b000010);
`else
  assign op_j       = 1'b0;
`endif
  assign decode_legal = op_lw | op_sw | rtype_ok | op_ori | op_beq | op_j;

  // State register; reset aborts any instruction back to FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic; unused codes 12-15 fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (op_lw || op_sw)  state_d = S_MEMADDR;
        else if (rtype_ok)   state_d = S_REXEC;
        else if (op_ori)     state_d = S_IEXEC;
        else if (op_beq)     state_d = S_BRANCH;
        else if (op_j)       state_d = S_JUMP;
        else                 state_d = S_FETCH;
      end
      S_MEMADDR: state_d = op_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_REXEC:   state_d = S_RWB;
      S_IEXEC:   state_d = S_IWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode; everything is gated to 0 while rst is high so no strobe survives an abort
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'b00;
    Illegal  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'b01;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          Illegal = ~decode_legal;
        end
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_REXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = funct_subu ? 2'b01 : 2'b00;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b10;
        end
        S_IWB: begin
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b01;
          PCSource = 2'b01;
          PCWrite  = Zero;
        end
`ifdef CTRL_JUMP_EN
        S_JUMP: begin
          PCSource = 2'b10;
          PCWrite  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
  logic       IorD, RegDst, MemToReg, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  logic [15:0] ctrl;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IorD(IorD), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  // {PCWrite,IRWrite,MemRead,MemWrite,RegWrite,IorD,RegDst,MemToReg,ALUSrcA,ALUSrcB,ALUOp,PCSource,Illegal}
  assign ctrl = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IorD, RegDst, MemToReg,
                 ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; Op = 6'b100011; Funct = 6'd0; Zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (State !== 4'd0 || ctrl !== 16'h0000) begin
        tests_failed++;
        $display("FAIL reset_hold cyc%0d: State=%0d ctrl=%h, expected State=0 ctrl=0000", i, State, ctrl);
      end
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (State !== 4'd0 || ctrl !== 16'hE020) begin
      tests_failed++;
      $display("FAIL reset_release_fetch: State=%0d ctrl=%h, expected State=0 ctrl=e020", State, ctrl);
    end
    step();
    tests_run++;
    if (State !== 4'd1) begin
      tests_failed++;
      $display("FAIL reset_first_decode: State=%0d, expected 1", State);
    end
    for (int i = 0; i < 4; i++) step();
    tests_run++;
    if (State !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_lw_return: State=%0d, expected 0", State);
    end
  endtask

  task automatic test_lw();
    logic [3:0]  es [0:5];
    logic [15:0] ec [0:5];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    ec = '{16'hE020, 16'h0060, 16'h00C0, 16'h2400, 16'h0900, 16'hE020};
    Op = 6'b100011; Funct = 6'd0; Zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (State !== es[i] || ctrl !== ec[i]) begin
        tests_failed++;
        $display("FAIL lw cyc%0d: State=%0d ctrl=%h, expected State=%0d ctrl=%h", i, State, ctrl, es[i], ec[i]);
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_sw();
    logic [3:0]  es [0:4];
    logic [15:0] ec [0:4];
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    ec = '{16'hE020, 16'h0060, 16'h00C0, 16'h1400, 16'hE020};
    Op = 6'b101011; Funct = 6'd0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (State !== es[i] || ctrl !== ec[i]) begin
        tests_failed++;
        $display("FAIL sw cyc%0d: State=%0d ctrl=%h, expected State=%0d ctrl=%h", i, State, ctrl, es[i], ec[i]);
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [15:0] exec_ctrl, input string nm);
    logic [3:0]  es [0:4];
    logic [15:0] ec [0:4];
    es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    ec = '{16'hE020, 16'h0060, exec_ctrl, 16'h0A00, 16'hE020};
    Op = 6'b000000; Funct = fn;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (State !== es[i] || ctrl !== ec[i]) begin
        tests_failed++;
        $display("FAIL %s cyc%0d: State=%0d ctrl=%h, expected State=%0d ctrl=%h", nm, i, State, ctrl, es[i], ec[i]);
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_ori();
    logic [3:0]  es [0:4];
    logic [15:0] ec [0:4];
    es = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd0};
    ec = '{16'hE020, 16'h0060, 16'h00D0, 16'h0800, 16'hE020};
    Op = 6'b001101; Funct = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (State !== es[i] || ctrl !== ec[i]) begin
        tests_failed++;
        $display("FAIL ori cyc%0d: State=%0d ctrl=%h, expected State=%0d ctrl=%h", i, State, ctrl, es[i], ec[i]);
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_beq(input logic z);
    logic [3:0]  es [0:3];
    logic [15:0] ec [0:3];
    es = '{4'd0, 4'd1, 4'd10, 4'd0};
    ec = '{16'hE020, 16'h0060, z ? 16'h808A : 16'h008A, 16'hE020};
    Op = 6'b000100; Funct = 6'd0; Zero = z;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (State !== es[i] || ctrl !== ec[i]) begin
        tests_failed++;
        $display("FAIL beq_z%0d cyc%0d: State=%0d ctrl=%h, expected State=%0d ctrl=%h", z, i, State, ctrl, es[i], ec[i]);
      end
      if (i < 3) step();
    end
    Zero = 1'b0;
  endtask

  task automatic test_illegal(input logic [5:0] op, input string nm);
    logic [3:0]  es [0:2];
    logic [15:0] ec [0:2];
    es = '{4'd0, 4'd1, 4'd0};
    ec = '{16'hE020, 16'h0061, 16'hE020};
    Op = op; Funct = 6'd0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (State !== es[i] || ctrl !== ec[i]) begin
        tests_failed++;
        $display("FAIL %s cyc%0d: State=%0d ctrl=%h, expected State=%0d ctrl=%h", nm, i, State, ctrl, es[i], ec[i]);
      end
      if (i < 2) step();
    end
  endtask

  task automatic test_jump();
    logic [3:0]  es [0:3];
    logic [15:0] ec [0:3];
    es = '{4'd0, 4'd1, 4'd11, 4'd0};
    ec = '{16'hE020, 16'h0060, 16'h8004, 16'hE020};
    Op = 6'b000010; Funct = 6'd0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (State !== es[i] || ctrl !== ec[i]) begin
        tests_failed++;
        $display("FAIL jump cyc%0d: State=%0d ctrl=%h, expected State=%0d ctrl=%h", i, State, ctrl, es[i], ec[i]);
      end
      if (i < 3) step();
    end
  endtask

  task automatic test_mid_reset();
    Op = 6'b101011; Funct = 6'd0;
    step(); step(); step();
    tests_run++;
    if (State !== 4'd5 || MemWrite !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_reach_memwr: State=%0d MemWrite=%b, expected State=5 MemWrite=1", State, MemWrite);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (State !== 4'd0 || MemWrite !== 1'b0 || ctrl !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midrst_abort: State=%0d MemWrite=%b ctrl=%h, expected State=0 MemWrite=0 ctrl=0000", State, MemWrite, ctrl);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (State !== 4'd0 || ctrl !== 16'hE020) begin
      tests_failed++;
      $display("FAIL midrst_refetch: State=%0d ctrl=%h, expected State=0 ctrl=e020", State, ctrl);
    end
    step();
    tests_run++;
    if (State !== 4'd1) begin
      tests_failed++;
      $display("FAIL midrst_decode: State=%0d, expected 1", State);
    end
    step(); step(); step();
    tests_run++;
    if (State !== 4'd0) begin
      tests_failed++;
      $display("FAIL midrst_sw_done: State=%0d, expected 0", State);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype(6'b100011, 16'h0088, "subu");
    test_rtype(6'b100001, 16'h0080, "addu");
    test_ori();
    test_beq(1'b1);
    test_beq(1'b0);
    test_illegal(6'b111111, "illegal_op3f");
    test_illegal(6'b000000, "illegal_bad_funct");
`ifdef CTRL_JUMP_EN
    test_jump();
`else
    test_illegal(6'b000010, "illegal_j_disabled");
`endif
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings SHALL be fixed by this document.
REQ-002 clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 Op  input  6  opcode field of the instruction register, stable from the cycle after FETCH.
REQ-005 Funct  input  6  function field of the instruction register, used when Op=000000.
REQ-006 Zero  input  1  ALU zero flag, combinational from the current ALU operands.
REQ-007 PCWrite, IRWrite, MemRead, MemWrite, RegWrite  output  1 each  write/read strobes.
REQ-008 IorD, RegDst, MemToReg, ALUSrcA  output  1 each  datapath mux selects.
REQ-009 ALUSrcB  output  2  00=reg B, 01=const 4, 10=signext imm, 11=signext imm<<2.
REQ-010 ALUOp  output  2  00=add, 01=sub, 10=or; 11 SHALL never be driven.
REQ-011 PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
REQ-012 Illegal  output  1  one-cycle pulse on an undecodable instruction.
REQ-013 State  output  4  current state code, for debug.

Function
REQ-014 States and codes SHALL be: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, IEXEC=8, IWB=9, BRANCH=10, JUMP=11; codes 12-15 SHALL go to FETCH.
REQ-015 FETCH SHALL assert MemRead, IRWrite and PCWrite, with IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00 and PCSource=00; next state is DECODE.
REQ-016 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUOp=00 so ALUOut holds the branch target.
REQ-017 Next state from DECODE SHALL be:
- lw (100011) or sw (101011) -> MEMADDR
- Op=000000 with Funct addu (100001) or subu (100011) -> REXEC
- ori (001101) -> IEXEC
- beq (000100) -> BRANCH
- j (000010) -> JUMP
- anything else -> FETCH with Illegal=1.
REQ-018 MEMADDR SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00; next is MEMRD for lw or MEMWR for sw.
REQ-019 MEMRD SHALL drive MemRead=1 and IorD=1, then go to MEMWB. MEMWB SHALL drive RegWrite=1, MemToReg=1 and RegDst=0, then go to FETCH.
REQ-020 MEMWR SHALL drive MemWrite=1 and IorD=1, then go to FETCH.
REQ-021 REXEC SHALL drive ALUSrcA=1 and ALUSrcB=00, with ALUOp=00 for addu and 01 for subu, then go to RWB. RWB SHALL drive RegWrite=1, RegDst=1 and MemToReg=0, then go to FETCH.
REQ-022 IEXEC SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=10, then go to IWB. IWB SHALL drive RegWrite=1, RegDst=0 and MemToReg=0, then go to FETCH.
REQ-023 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01 and PCWrite=Zero (Mealy, combinational), then go to FETCH.
REQ-024 JUMP SHALL drive PCSource=10 and PCWrite=1, then go to FETCH.
REQ-025 All signals not listed for a state SHALL be 0. Except for REQ-023, outputs SHALL be Moore (a function of State only).
REQ-026 Cycles per instruction SHALL be: lw 5; sw, R-type and ori 4; beq and j 3; illegal 2.
REQ-027 MemRead and MemWrite SHALL never be asserted in the same cycle, and RegWrite SHALL never coincide with MemWrite.
REQ-028 Op and Funct SHALL be sampled every cycle. The datapath keeps them stable after FETCH, so no internal copy is required.

Reset
REQ-029 While rst=1, State SHALL be FETCH and every output, including Illegal, SHALL be forced to 0 combinationally.
REQ-030 The first FETCH cycle with active controls SHALL be the first clk cycle after rst deasserts.
REQ-031 rst asserted in any state SHALL abort the instruction immediately, with no partial write strobe after assertion.

Configuration
REQ-032 With macro CTRL_JUMP_EN defined, j SHALL be decoded per REQ-017 and REQ-024.
REQ-033 Without CTRL_JUMP_EN, Op=000010 SHALL be illegal (DECODE -> FETCH, Illegal=1), state JUMP SHALL be unreachable, and PCSource SHALL never equal 10.

Verification
REQ-034 Reset: hold rst=1 for 3 cycles with Op=100011 -> all outputs 0 and State=0; release -> next edge State=1, with FETCH strobes seen in the cycle before.
REQ-035 lw: Op=100011 -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemToReg=1 only in state 4; MemRead=1 in states 0 and 3.
REQ-036 subu: Op=0 and Funct=100011 -> ALUOp=01 in state 6; RegDst=1 and RegWrite=1 in state 7; 4 cycles total.
REQ-037 beq: Op=000100 -> with Zero=1, PCWrite=1 and PCSource=01 in state 10; with Zero=0, PCWrite=0; 3 cycles each.
REQ-038 Illegal: Op=111111 -> Illegal pulses once in state 1, next state is 0, and no write strobe fires. Without CTRL_JUMP_EN, Op=000010 gives the same result.
REQ-039 Mid-operation reset: assert rst during state 5 (sw) -> MemWrite=0 immediately and State=0; on release, fetch resumes normally.
